// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard/sequencing controller for the 5-stage RV32I pipeline
// Optional performance counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
// Outputs are combinational from registered state plus current inputs; the stage
// registers downstream re-register them.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_miss,
  input  logic             refill_ack,
  output logic             refill_req,
  output logic             refill_err,
  input  logic             memread_E,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,
  input  logic             jal_D,
  input  logic             br_E,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             bubbleE,
  output logic             bubbleM,
  output logic             bubbleW,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW
);

  // Watchdog is just wide enough to hold TIMEOUT_CYCLES.
  localparam int WD_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};

  // Reject nonsensical configurations at elaboration.
  if (CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pipe_hazard_ctrl: CNT_W and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REFILL = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            pend_q, pend_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;
  logic            lu;

  // Load-use: the load in EX writes a register the ID instruction actually reads (x0 never hazards).
  assign lu = memread_E && (rd_E != 5'd0) &&
              ((rs1_used_D && (rs1_D == rd_E)) || (rs2_used_D && (rs2_D == rd_E)));

  // Next-state: a miss starts a refill unless a redirect in EX makes the fetch moot;
  // redirects seen while refilling are remembered and replayed as a D flush after ack.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        pend_d = 1'b0;
        wdog_d = '0;
        if (icache_miss && !br_E) begin
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (br_E) begin
          pend_d = 1'b1;
        end
        if (refill_ack) begin
          state_d = ST_RUN;
          wdog_d  = '0;
        end else if (wdog_q == WD_LIMIT) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (wdog_q != WD_MAX) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        pend_d  = 1'b0;
        wdog_d  = '0;
      end
    endcase
  end

  // State, pending redirect, watchdog and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // Stage control: redirect beats load-use beats JAL beats miss; refill holds F/D
  // and keeps inserting NOPs into EX so the held D instruction is not duplicated.
  always_comb begin
    bubbleF    = 1'b0;
    bubbleD    = 1'b0;
    bubbleE    = 1'b0;
    bubbleM    = 1'b0;
    bubbleW    = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushM     = 1'b0;
    flushW     = 1'b0;
    refill_req = 1'b0;
    if (rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          flushD = pend_q;
          if (br_E) begin
            flushD = 1'b1;
            flushE = 1'b1;
          end else if (lu) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            flushE  = 1'b1;
          end else if (jal_D) begin
            flushD = 1'b1;
          end else if (icache_miss) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
          end
        end
        ST_REFILL: begin
          refill_req = !refill_ack;
          bubbleF    = 1'b1;
          bubbleD    = 1'b1;
          flushE     = 1'b1;
        end
        ST_ERR: begin
          bubbleF = 1'b1;
          bubbleD = 1'b1;
          bubbleE = 1'b1;
          bubbleM = 1'b1;
          bubbleW = 1'b1;
        end
        default: begin
          bubbleF = 1'b0;
        end
      endcase
    end
  end

  assign refill_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Stall and flush event counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bubbleD) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flushD || flushE) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline.
- Drives per-stage bubble (hold) and flush (insert NOP) signals for F/D/E/M/W.
- Covers load-use stalls, branch/jump redirects and instruction-cache refill sequencing (req/ack handshake to memory); includes a refill watchdog.
- Sits beside the datapath. bubbleD/flushD feed the IF/ID stage register, which re-registers them internally, so this block's outputs are combinational from registered state plus current inputs.

Parameters:
- TIMEOUT_CYCLES, 255: refill cycles allowed before refill_err is raised.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk, input, 1: pipeline clock.
- rst, input, 1: asynchronous, active-high reset.
- icache_miss, input, 1: fetch address missed in the instruction cache this cycle.
- refill_ack, input, 1: memory has completed the line refill. Single-cycle pulse.
- refill_req, output, 1: refill request. Level signal, held until ack.
- refill_err, output, 1: watchdog expired. Sticky until rst.
- memread_E, input, 1: instruction in EX is a load.
- rd_E, input, 5: destination register of the EX instruction.
- rs1_D, input, 5: source register 1 of the ID instruction.
- rs2_D, input, 5: source register 2 of the ID instruction.
- rs1_used_D, input, 1: ID instruction reads rs1.
- rs2_used_D, input, 1: ID instruction reads rs2.
- jal_D, input, 1: JAL resolved in ID.
- br_E, input, 1: taken branch or JALR resolved in EX.
- bubbleF, bubbleD, bubbleE, bubbleM, bubbleW, output, 1 each: hold the stage register.
- flushD, flushE, flushM, flushW, output, 1 each: load a NOP into the stage register.

Behaviour:
- State register: RUN, REFILL, ERR. rst forces RUN asynchronously and clears the pending-redirect flag, the watchdog counter and refill_err.
- While rst is high: all bubbles 0, flushD/E/M/W = 1, refill_req = 0.
- Load-use hazard (lu) = memread_E & rd_E != 0 & ((rs1_used_D & rs1_D == rd_E) | (rs2_used_D & rs2_D == rd_E)).
- RUN, priority from highest:
  - br_E: flushD = flushE = 1; overrides lu and jal_D.
  - lu: bubbleF = bubbleD = 1, flushE = 1. Exactly one bubble per load-use pair.
  - jal_D: flushD = 1.
  - icache_miss with no br_E: bubbleF = bubbleD = 1, flushD = 0. Next state REFILL. refill_req rises the following cycle.
  - icache_miss with br_E: the redirect wins, the miss is ignored, state stays RUN.
- REFILL:
  - refill_req = 1, bubbleF = bubbleD = 1.
  - E/M/W continue. flushE = 1 every cycle so that no instruction is duplicated.
  - A br_E arriving in REFILL sets the pending flag; flushE still applies.
  - The watchdog counter increments each cycle.
  - refill_ack: refill_req drops in the same cycle, next state RUN, counter clears.
  - Pending flag set at ack: flushD = 1 on the first RUN cycle, then the flag clears.
  - Counter reaching TIMEOUT_CYCLES with no ack: next state ERR.
- ERR: refill_err = 1, refill_req = 0, bubbleF/D/E/M/W all 1, flushes 0. Exit only through rst.
- refill_ack outside REFILL is ignored.
- icache_miss is sampled only in RUN.
- bubbleE/M/W are 0 except in ERR.
- The watchdog counter is ceil(log2(TIMEOUT_CYCLES+1)) bits wide and saturates.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN defined: adds outputs stall_cnt [CNT_W-1:0] and flush_cnt [CNT_W-1:0]. Both clear on rst.
  - stall_cnt +1 each cycle that bubbleD = 1.
  - flush_cnt +1 each cycle that flushD | flushE = 1.
  - Both wrap modulo 2^CNT_W.
- Macro undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load-use: memread_E=1, rd_E=5, rs1_D=5, rs1_used_D=1 -> exactly one cycle with bubbleF=bubbleD=1 and flushE=1. Repeat with rd_E=0 -> no stall.
- Branch beats load-use: br_E=1 with the lu conditions above -> flushD=flushE=1, bubbleF=bubbleD=0.
- Refill handshake: icache_miss pulse -> refill_req=1 from the next cycle. refill_ack after 7 cycles -> refill_req=0 in the ack cycle, bubbleD=1 for 8 cycles total, then RUN.
- Redirect during refill: br_E=1 in the 3rd REFILL cycle -> flushE that cycle. After ack, exactly one flushD cycle.
- Watchdog: TIMEOUT_CYCLES=4, no ack -> refill_err=1 in the 6th cycle after the miss, all bubbles=1. Async rst mid-ERR -> immediate RUN, refill_err=0.
- HAZARD_PERF_CNT_EN: the refill scenario plus one load-use -> stall_cnt=9. One branch -> flush_cnt increments by 1.
